race_reaction_timer: RTL and testbench
======================================

# race_reaction_timer

Driver-side consumer of the race start lights: samples the one-hot {RED, YELLOW, GREEN} light code driven by the lights controller, together with a driver LAUNCH button, and reports either a reaction time in clock cycles (green-to-launch) or a false start. Sits downstream of the lights controller on the same clock. Results are held until acknowledged by the scoreboard/display logic.

## Interface
- CNT_W, 8, reaction counter and REACT_TIME width
- TIMEOUT, 200, cycles in TIMING before abort; used only with RRT_TIMEOUT_EN; must be ≤ 2^CNT_W−1
- One clock; reset is synchronous and active-high.
- CLOCK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high reset
- RED  in  1  red light from controller
- YELLOW  in  1  yellow light from controller
- GREEN  in  1  green light from controller
- LAUNCH  in  1  driver launch button, synchronous to CLOCK, level-sampled
- ACK  in  1  result acknowledge; releases the held result
- REACT_TIME  out  CNT_W  captured reaction time, valid while VALID=1
- VALID  out  1  reaction result held
- FALSE_START  out  1  launch before green, held
- LIGHT_ERR  out  1  sticky: non-one-hot light code seen while active
- TIMED_OUT  out  1  no launch within TIMEOUT cycles (constant 0 without macro)

## Operation
- Light code L = {RED,YELLOW,GREEN}; valid codes 100 (R), 010 (Y), 001 (G); all others invalid.
- States: IDLE, STAGED, ARMED, TIMING, RESULT, FOUL, plus TMO with macro.
- IDLE: L=R → STAGED. All else ignored, including LAUNCH and ACK.
- STAGED: LAUNCH → FOUL. Else L=Y → ARMED. Else L=G → TIMING (skipped yellow is legal).
- ARMED: LAUNCH → FOUL. Else L=G → TIMING. L=R stays ARMED.
- Entry to TIMING loads CNT=1.
- TIMING: LAUNCH → RESULT with REACT_TIME←CNT. Else L=R → STAGED (run aborted, no result). Else CNT←CNT+1, saturating at 2^CNT_W−1.
- RESULT: VALID=1, REACT_TIME held. ACK → IDLE.
- FOUL: FALSE_START=1. ACK → IDLE.
- Priority in every active state: LAUNCH > light change. LAUNCH sampled on the same edge green is first seen in ARMED/STAGED is a false start.
- An invalid L in STAGED/ARMED/TIMING sets LIGHT_ERR and is treated as no change (state holds, CNT still increments in TIMING). Invalid L in IDLE/RESULT/FOUL is ignored.
- LIGHT_ERR is cleared only by ACK in RESULT/FOUL/TMO, or by RESET.
- ACK outside RESULT/FOUL/TMO is ignored.
- REACT_TIME holds its last value until the next capture. It is not cleared by ACK.

## Timing
- All outputs are registered. On RESET: state IDLE, REACT_TIME=0, VALID=0, FALSE_START=0, LIGHT_ERR=0, TIMED_OUT=0, CNT=0.
- RESET asserted mid-run wins on that edge, regardless of LAUNCH/ACK.
- Green first sampled at edge k, LAUNCH first sampled at edge k+n (n≥1) → REACT_TIME=n. VALID rises on the register update of edge k+n (zero extra latency).
- Saturation: if n ≥ 2^CNT_W−1, REACT_TIME = 2^CNT_W−1.
- VALID/FALSE_START/TIMED_OUT deassert on the edge ACK is sampled. At the earliest, a new run can begin (L=R) on the following edge.
- A held LAUNCH after ACK does not re-trigger: from IDLE, LAUNCH is ignored.

## Configuration
- RRT_TIMEOUT_EN defined: in TIMING, if no LAUNCH and CNT=TIMEOUT, go to TMO on that edge. TMO sets TIMED_OUT=1 and VALID=0. ACK → IDLE. LAUNCH on the same edge wins (RESULT with REACT_TIME=TIMEOUT).
- RRT_TIMEOUT_EN undefined: no TMO state; TIMED_OUT tied 0; TIMING waits indefinitely with a saturating CNT.

## Test plan
- L: 100 → 010 → 001, LAUNCH on the 5th edge after green first sampled → VALID=1, REACT_TIME=5, FALSE_START=0; ACK → VALID=0, state IDLE.
- L=010 with LAUNCH=1 → FALSE_START=1 next edge, VALID=0. LAUNCH on the same edge as first 001 → FALSE_START=1.
- L=011 injected during ARMED → LIGHT_ERR=1, state stays ARMED. Later green + launch gives a correct REACT_TIME; ACK clears LIGHT_ERR.
- CNT_W=4, no launch for 20 cycles (macro off), then LAUNCH → REACT_TIME=15. L returns to 100 mid-TIMING without launch → back to STAGED, VALID stays 0.
- With RRT_TIMEOUT_EN, TIMEOUT=10, no launch → TIMED_OUT=1 at CNT=10. RESET asserted in TIMING with LAUNCH=1 → all outputs 0, state IDLE.

Source files
------------

// File: rtl/race_reaction_timer.sv
// Driver-side reaction timer: measures green-to-launch cycles or flags a false start.
// Optional abort on no launch within TIMEOUT cycles is enabled by defining RRT_TIMEOUT_EN.
module race_reaction_timer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             RED,
  input  logic             YELLOW,
  input  logic             GREEN,
  input  logic             LAUNCH,
  input  logic             ACK,
  output logic [CNT_W-1:0] REACT_TIME,
  output logic             VALID,
  output logic             FALSE_START,
  output logic             LIGHT_ERR,
  output logic             TIMED_OUT
);

`ifdef RRT_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_STAGED, S_ARMED, S_TIMING, S_RESULT, S_FOUL, S_TMO
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_STAGED, S_ARMED, S_TIMING, S_RESULT, S_FOUL
  } state_t;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // TIMEOUT has to be reachable by the saturating counter.
  if (TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_timeout
    $error("race_reaction_timer: TIMEOUT exceeds counter range");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_r;
  logic             is_y;
  logic             is_g;
  logic             is_bad;

  always_comb begin
    is_r   = ({RED, YELLOW, GREEN} == 3'b100);
    is_y   = ({RED, YELLOW, GREEN} == 3'b010);
    is_g   = ({RED, YELLOW, GREEN} == 3'b001);
    is_bad = !(is_r || is_y || is_g);
  end

`ifdef RRT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
  logic timed_out_q;
  assign TIMED_OUT = timed_out_q;
`else
  assign TIMED_OUT = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= S_IDLE;
      cnt         <= '0;
      REACT_TIME  <= '0;
      VALID       <= 1'b0;
      FALSE_START <= 1'b0;
      LIGHT_ERR   <= 1'b0;
`ifdef RRT_TIMEOUT_EN
      timed_out_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (is_r) state <= S_STAGED;
        end

        S_STAGED, S_ARMED: begin
          if (is_bad) LIGHT_ERR <= 1'b1;
          if (LAUNCH) begin
            state       <= S_FOUL;
            FALSE_START <= 1'b1;
          end else if (is_g) begin
            state <= S_TIMING;
            cnt   <= CNT_W'(1);
          end else if (is_y) begin
            state <= S_ARMED;
          end
        end

        S_TIMING: begin
          if (is_bad) LIGHT_ERR <= 1'b1;
          if (LAUNCH) begin
            state      <= S_RESULT;
            REACT_TIME <= cnt;
            VALID      <= 1'b1;
          end else if (is_r) begin
            state <= S_STAGED;
          end else begin
`ifdef RRT_TIMEOUT_EN
            if (cnt == TMO_CNT) begin
              state       <= S_TMO;
              timed_out_q <= 1'b1;
            end else
`endif
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end
        end

`ifdef RRT_TIMEOUT_EN
        S_RESULT, S_FOUL, S_TMO: begin
`else
        S_RESULT, S_FOUL: begin
`endif
          if (ACK) begin
            state       <= S_IDLE;
            VALID       <= 1'b0;
            FALSE_START <= 1'b0;
            LIGHT_ERR   <= 1'b0;
`ifdef RRT_TIMEOUT_EN
            timed_out_q <= 1'b0;
`endif
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_race_reaction_timer.sv
// Self-checking bench for race_reaction_timer: directed scenarios plus randomized runs
// checked against a run-outcome model built from the light/launch sequence.
module tb_race_reaction_timer;

  localparam int unsigned CW   = 4;
  localparam int unsigned TO   = 10;
  localparam int          CMAX = (1 << CW) - 1;

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b0;
  logic          RED = 1'b0, YELLOW = 1'b0, GREEN = 1'b0;
  logic          LAUNCH = 1'b0;
  logic          ACK = 1'b0;
  logic [CW-1:0] REACT_TIME;
  logic          VALID, FALSE_START, LIGHT_ERR, TIMED_OUT;

  int checks = 0;
  int errors = 0;

  logic [2:0] seq_l[$];
  bit         seq_la[$];

  race_reaction_timer #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .RED(RED), .YELLOW(YELLOW), .GREEN(GREEN),
    .LAUNCH(LAUNCH), .ACK(ACK), .REACT_TIME(REACT_TIME), .VALID(VALID),
    .FALSE_START(FALSE_START), .LIGHT_ERR(LIGHT_ERR), .TIMED_OUT(TIMED_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic step(input logic [2:0] l, input logic la, input logic ak);
    {RED, YELLOW, GREEN} = l;
    LAUNCH = la;
    ACK    = ak;
    @(posedge CLOCK);
    #1;
  endtask

  // Outcome of one run: 0 none, 1 result, 2 false start, 3 timeout.
  // A run starts at the first red; reaction = edges between first green sample and launch.
  function automatic void predict(output int kind, output int react, output bit err);
    int  g_at;
    bit  started;
    kind = 0; react = 0; err = 0; g_at = -1; started = 0;
    for (int i = 0; i < seq_l.size(); i++) begin
      if (kind != 0) continue;
      if (!started) begin
        if (seq_l[i] == LR) started = 1;
        continue;
      end
      if (!(seq_l[i] inside {LR, LY, LG})) err = 1;
      if (seq_la[i]) begin
        if (g_at >= 0) begin
          kind  = 1;
          react = (i - g_at > CMAX) ? CMAX : i - g_at;
        end else begin
          kind = 2;
        end
      end else if (g_at < 0) begin
        if (seq_l[i] == LG) g_at = i;
      end else if (seq_l[i] == LR) begin
        g_at = -1;
      end
`ifdef RRT_TIMEOUT_EN
      else if (i - g_at == TO) kind = 3;
`endif
    end
  endfunction

  task automatic test_reset();
    RESET = 1'b1;
    step(LG, 1'b1, 1'b1);
    RESET = 1'b0;
    checks++; if ({REACT_TIME, VALID, FALSE_START, LIGHT_ERR, TIMED_OUT} !== '0) begin errors++;
      $display("FAIL reset_outputs got %h exp 0", {REACT_TIME, VALID, FALSE_START, LIGHT_ERR, TIMED_OUT}); end
    step(LG, 1'b1, 1'b0);
    checks++; if (FALSE_START !== 1'b0 || VALID !== 1'b0) begin errors++;
      $display("FAIL idle_ignores_launch got fs=%b v=%b exp 0 0", FALSE_START, VALID); end
  endtask

  task automatic test_basic();
    step(LR, 0, 0); step(LY, 0, 0); step(LG, 0, 0);
    repeat (4) step(LG, 0, 0);
    step(LG, 1, 0);
    checks++; if (VALID !== 1'b1 || REACT_TIME !== CW'(5) || FALSE_START !== 1'b0) begin errors++;
      $display("FAIL basic_result got v=%b rt=%0d fs=%b exp 1 5 0", VALID, REACT_TIME, FALSE_START); end
    step(LG, 1, 1);
    checks++; if (VALID !== 1'b0 || REACT_TIME !== CW'(5)) begin errors++;
      $display("FAIL basic_ack got v=%b rt=%0d exp 0 5", VALID, REACT_TIME); end
    step(LY, 1, 0);
    checks++; if (FALSE_START !== 1'b0 || VALID !== 1'b0) begin errors++;
      $display("FAIL held_launch_after_ack got fs=%b v=%b exp 0 0", FALSE_START, VALID); end
  endtask

  task automatic test_false_start();
    step(LR, 0, 0); step(LY, 1, 0);
    checks++; if (FALSE_START !== 1'b1 || VALID !== 1'b0) begin errors++;
      $display("FAIL fs_yellow got fs=%b v=%b exp 1 0", FALSE_START, VALID); end
    step(LY, 0, 1);
    checks++; if (FALSE_START !== 1'b0) begin errors++;
      $display("FAIL fs_ack got fs=%b exp 0", FALSE_START); end
    step(LR, 0, 0); step(LY, 0, 0); step(LG, 1, 0);
    checks++; if (FALSE_START !== 1'b1 || VALID !== 1'b0) begin errors++;
      $display("FAIL fs_same_edge_green got fs=%b v=%b exp 1 0", FALSE_START, VALID); end
    step(LG, 0, 1);
  endtask

  task automatic test_light_err();
    step(LR, 0, 0); step(LY, 0, 0); step(3'b011, 0, 0);
    checks++; if (LIGHT_ERR !== 1'b1 || FALSE_START !== 1'b0) begin errors++;
      $display("FAIL lerr_set got le=%b fs=%b exp 1 0", LIGHT_ERR, FALSE_START); end
    step(LY, 0, 0); step(LG, 0, 0); step(LG, 0, 0); step(LG, 0, 0); step(LG, 1, 0);
    checks++; if (VALID !== 1'b1 || REACT_TIME !== CW'(3) || LIGHT_ERR !== 1'b1) begin errors++;
      $display("FAIL lerr_result got v=%b rt=%0d le=%b exp 1 3 1", VALID, REACT_TIME, LIGHT_ERR); end
    step(LG, 0, 1);
    checks++; if (LIGHT_ERR !== 1'b0 || VALID !== 1'b0) begin errors++;
      $display("FAIL lerr_ack got le=%b v=%b exp 0 0", LIGHT_ERR, VALID); end
  endtask

  task automatic test_saturation();
    step(LR, 0, 0); step(LG, 0, 0);
    repeat (20) step(LG, 0, 0);
    step(LG, 1, 0);
    checks++; if (VALID !== 1'b1 || REACT_TIME !== CW'(CMAX)) begin errors++;
      $display("FAIL saturate got v=%b rt=%0d exp 1 %0d", VALID, REACT_TIME, CMAX); end
    step(LG, 0, 1);
    step(LR, 0, 0); step(LY, 0, 0); step(LG, 0, 0); step(LG, 0, 0); step(LR, 0, 0);
    checks++; if (VALID !== 1'b0 || FALSE_START !== 1'b0 || REACT_TIME !== CW'(CMAX)) begin errors++;
      $display("FAIL abort_to_staged got v=%b fs=%b rt=%0d exp 0 0 %0d", VALID, FALSE_START, REACT_TIME, CMAX); end
    step(LY, 1, 0);
    checks++; if (FALSE_START !== 1'b1) begin errors++;
      $display("FAIL abort_state_active got fs=%b exp 1", FALSE_START); end
    step(LY, 0, 1);
  endtask

  task automatic test_reset_midrun();
    step(LR, 0, 0); step(LG, 0, 0); step(LG, 0, 0);
    RESET = 1'b1;
    step(LG, 1, 0);
    RESET = 1'b0;
    checks++; if ({REACT_TIME, VALID, FALSE_START, LIGHT_ERR, TIMED_OUT} !== '0) begin errors++;
      $display("FAIL midrun_reset got %h exp 0", {REACT_TIME, VALID, FALSE_START, LIGHT_ERR, TIMED_OUT}); end
    step(LG, 1, 0);
    checks++; if (VALID !== 1'b0 || FALSE_START !== 1'b0) begin errors++;
      $display("FAIL midrun_reset_idle got v=%b fs=%b exp 0 0", VALID, FALSE_START); end
  endtask

  task automatic test_random();
    int kind, react;
    bit err;
    logic [2:0] l;
    for (int r = 0; r < 40; r++) begin
      seq_l.delete(); seq_la.delete();
      for (int i = 0; i < int'($urandom_range(40, 10)); i++) begin
        case ($urandom_range(9, 0))
          0, 1:    l = LR;
          2, 3:    l = LY;
          4, 5, 6, 7: l = LG;
          default: l = 3'($urandom_range(7, 0));
        endcase
        if (i == 0 && $urandom_range(1, 0) == 1) l = LR;
        seq_l.push_back(l);
        seq_la.push_back($urandom_range(11, 0) == 0);
      end
      predict(kind, react, err);
      RESET = 1'b1; step(3'b000, 0, 0); RESET = 1'b0;
      for (int i = 0; i < seq_l.size(); i++) step(seq_l[i], seq_la[i], 1'b0);
      checks++; if (VALID !== (kind == 1) || FALSE_START !== (kind == 2) || TIMED_OUT !== (kind == 3)) begin errors++;
        $display("FAIL rand%0d_flags got v=%b fs=%b to=%b exp kind %0d", r, VALID, FALSE_START, TIMED_OUT, kind); end
      checks++; if (REACT_TIME !== CW'(react)) begin errors++;
        $display("FAIL rand%0d_react got %0d exp %0d", r, REACT_TIME, react); end
      checks++; if (LIGHT_ERR !== err) begin errors++;
        $display("FAIL rand%0d_lerr got %b exp %b", r, LIGHT_ERR, err); end
      if (kind != 0) begin
        step(3'b000, 1'b1, 1'b1);
        checks++; if ({VALID, FALSE_START, LIGHT_ERR, TIMED_OUT} !== 4'b0 || REACT_TIME !== CW'(react)) begin errors++;
          $display("FAIL rand%0d_ack got %b rt=%0d exp 0000 %0d", r, {VALID, FALSE_START, LIGHT_ERR, TIMED_OUT}, REACT_TIME, react); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_light_err();
    test_saturation();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
